// File: rtl/actag_map_pkg.sv
// Shared types and opcodes for the acTag<->PASID mapper on the AFU->TLX command path.
package actag_map_pkg;

   localparam logic [7:0] ASSIGN_ACTAG = 8'h50;
   localparam logic [7:0] DMA_W        = 8'h20;
   localparam logic [7:0] DMA_PR_W     = 8'h30;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [15:0] afutag;
      logic [67:0] ea_or_obj;
      logic [1:0]  dl;
      logic [2:0]  pl;
      logic [19:0] pasid;
   } cmd_t;

   function automatic logic is_dma_write(input logic [7:0] op);
      return (op == DMA_W) || (op == DMA_PR_W);
   endfunction

endpackage

// File: rtl/actag_map_table.sv
// Flop-based acTag table: one tag + valid per index, combinational read.
module actag_map_table #(
   parameter int CTXW    = 9,
   parameter int ACTAG_W = 6
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [ACTAG_W-1:0]        rd_idx,
   output logic                      rd_valid,
   output logic [CTXW-ACTAG_W-1:0]   rd_tag,
   input  logic                      wr_en,
   input  logic [ACTAG_W-1:0]        wr_idx,
   input  logic [CTXW-ACTAG_W-1:0]   wr_tag,
   input  logic                      clr_en,
   input  logic [ACTAG_W-1:0]        clr_idx,
   input  logic [CTXW-ACTAG_W-1:0]   clr_tag,
   input  logic                      flush
);

   localparam int DEPTH = 2 ** ACTAG_W;

   logic [DEPTH-1:0]              vld;
   logic [CTXW-ACTAG_W-1:0]       tag [DEPTH];

   assign rd_valid = vld[rd_idx];
   assign rd_tag   = tag[rd_idx];

   // Flush wins over everything; a clear only drops the entry if it still maps the same PASID.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld <= '0;
      end else if (flush) begin
         vld <= '0;
      end else begin
         if (clr_en && (tag[clr_idx] == clr_tag))
            vld[clr_idx] <= 1'b0;
         if (wr_en)
            vld[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         tag[wr_idx] <= wr_tag;
   end

endmodule

// File: rtl/actag_context_mapper.sv
// acTag<->PASID mapper: injects assign_actag ahead of commands whose PASID has no acTag mapping yet.
module actag_context_mapper
   import actag_map_pkg::*;
#(
   parameter int CTXW    = 9,
   parameter int ACTAG_W = 6,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [11:0]       cfg_actag_base,
   input  logic [19:0]       cfg_pasid_base,
   input  logic [19:0]       cfg_pasid_mask,
   input  logic              cfg_flush,
   input  logic              inval_valid,
   output logic              inval_ready,
   input  logic [19:0]       inval_pasid,
   input  logic              i_cmd_valid,
   output logic              i_cmd_ready,
   input  logic [7:0]        i_cmd_opcode,
   input  logic [15:0]       i_cmd_afutag,
   input  logic [67:0]       i_cmd_ea_or_obj,
   input  logic [1:0]        i_cmd_dl,
   input  logic [2:0]        i_cmd_pl,
   input  logic [19:0]       i_cmd_pasid,
   output logic              o_cmd_valid,
   input  logic              o_cmd_ready,
   output logic [7:0]        o_cmd_opcode,
   output logic [15:0]       o_cmd_afutag,
   output logic [67:0]       o_cmd_ea_or_obj,
   output logic [1:0]        o_cmd_dl,
   output logic [2:0]        o_cmd_pl,
   output logic [11:0]       o_cmd_actag,
   output logic [19:0]       o_cmd_pasid,
   output logic              wdata_rdrq,
   output logic              err_pasid,
   output logic [CNT_W-1:0]  stat_miss_cnt,
   output logic [CNT_W-1:0]  stat_cmd_cnt
);

   localparam int TAG_W = CTXW - ACTAG_W;

   cmd_t               s1_cmd, s2_cmd, s2_next;
   logic               s1_valid, rst_done;
   logic [11:0]        s2_actag, s1_actag;
   logic [ACTAG_W-1:0] s1_idx;
   logic [TAG_W-1:0]   s1_tag, tbl_tag;
   logic               tbl_valid, hit, s2_free, table_wr, s1_fire, i_fire, inval_fire;
   logic               unused_inval_hi;

   assign s1_idx   = s1_cmd.pasid[ACTAG_W-1:0];
   assign s1_tag   = s1_cmd.pasid[CTXW-1:ACTAG_W];
   assign s1_actag = cfg_actag_base + 12'(s1_idx);

   assign hit      = tbl_valid && (tbl_tag == s1_tag);
   assign s2_free  = !o_cmd_valid || o_cmd_ready;
   assign table_wr = s1_valid && !hit && s2_free;
   assign s1_fire  = s1_valid && hit && s2_free;

   // Both ready outputs stay low until the first edge after reset release.
   assign i_cmd_ready = rst_done && (!s1_valid || s1_fire);
   assign i_fire      = i_cmd_valid && i_cmd_ready;
   assign inval_ready = rst_done && !table_wr;
   assign inval_fire  = inval_valid && inval_ready;
   assign unused_inval_hi = ^inval_pasid;

   actag_map_table #(.CTXW(CTXW), .ACTAG_W(ACTAG_W)) u_table (
      .clk      (clk),
      .resetn   (resetn),
      .rd_idx   (s1_idx),
      .rd_valid (tbl_valid),
      .rd_tag   (tbl_tag),
      .wr_en    (table_wr),
      .wr_idx   (s1_idx),
      .wr_tag   (s1_tag),
      .clr_en   (inval_fire),
      .clr_idx  (inval_pasid[ACTAG_W-1:0]),
      .clr_tag  (inval_pasid[CTXW-1:ACTAG_W]),
      .flush    (cfg_flush)
   );

   always_comb begin
      s2_next = s1_cmd;
      if (!hit)
         s2_next.opcode = ASSIGN_ACTAG;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_done <= 1'b0;
         s1_valid <= 1'b0;
         s1_cmd   <= '0;
      end else begin
         rst_done <= 1'b1;
         if (i_fire) begin
            s1_valid <= 1'b1;
            s1_cmd   <= cmd_t'{i_cmd_opcode, i_cmd_afutag, i_cmd_ea_or_obj,
                               i_cmd_dl, i_cmd_pl, i_cmd_pasid};
         end else if (s1_fire) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // A miss leaves S1 in place, so the original command follows its assign_actag on the next free slot.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         o_cmd_valid <= 1'b0;
         s2_cmd      <= '0;
         s2_actag    <= '0;
         wdata_rdrq  <= 1'b0;
      end else begin
         wdata_rdrq <= s1_fire && is_dma_write(s1_cmd.opcode);
         if (s2_free) begin
            o_cmd_valid <= s1_valid;
            if (s1_valid) begin
               s2_cmd   <= s2_next;
               s2_actag <= s1_actag;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_miss_cnt <= '0;
         stat_cmd_cnt  <= '0;
         err_pasid     <= 1'b0;
      end else begin
         if (table_wr && (stat_miss_cnt != '1))
            stat_miss_cnt <= stat_miss_cnt + 1'b1;
         if (s1_fire && (stat_cmd_cnt != '1))
            stat_cmd_cnt <= stat_cmd_cnt + 1'b1;
         if (i_fire && ((i_cmd_pasid & cfg_pasid_mask) != (cfg_pasid_base & cfg_pasid_mask)))
            err_pasid <= 1'b1;
      end
   end

   assign o_cmd_opcode    = s2_cmd.opcode;
   assign o_cmd_afutag    = s2_cmd.afutag;
   assign o_cmd_ea_or_obj = s2_cmd.ea_or_obj;
   assign o_cmd_dl        = s2_cmd.dl;
   assign o_cmd_pl        = s2_cmd.pl;
   assign o_cmd_pasid     = s2_cmd.pasid;
   assign o_cmd_actag     = s2_actag;

endmodule

// File: tb/tb_actag_context_mapper.sv
// Directed bench for actag_context_mapper: miss/hit sequencing, backpressure, invalidate, flush, window error.
module tb_actag_context_mapper;

   logic        clk = 1'b0;
   logic        resetn;
   logic [11:0] cfg_actag_base;
   logic [19:0] cfg_pasid_base, cfg_pasid_mask;
   logic        cfg_flush;
   logic        inval_valid, inval_ready;
   logic [19:0] inval_pasid;
   logic        i_cmd_valid, i_cmd_ready;
   logic [7:0]  i_cmd_opcode;
   logic [15:0] i_cmd_afutag;
   logic [67:0] i_cmd_ea_or_obj;
   logic [1:0]  i_cmd_dl;
   logic [2:0]  i_cmd_pl;
   logic [19:0] i_cmd_pasid;
   logic        o_cmd_valid, o_cmd_ready;
   logic [7:0]  o_cmd_opcode;
   logic [15:0] o_cmd_afutag;
   logic [67:0] o_cmd_ea_or_obj;
   logic [1:0]  o_cmd_dl;
   logic [2:0]  o_cmd_pl;
   logic [11:0] o_cmd_actag;
   logic [19:0] o_cmd_pasid;
   logic        wdata_rdrq, err_pasid;
   logic [31:0] stat_miss_cnt, stat_cmd_cnt;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [11:0] actag;
      logic [19:0] pasid;
   } out_t;

   out_t obs[$];
   int   rdrq_cnt = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   actag_context_mapper dut (
      .clk(clk), .resetn(resetn),
      .cfg_actag_base(cfg_actag_base), .cfg_pasid_base(cfg_pasid_base),
      .cfg_pasid_mask(cfg_pasid_mask), .cfg_flush(cfg_flush),
      .inval_valid(inval_valid), .inval_ready(inval_ready), .inval_pasid(inval_pasid),
      .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_cmd_ready),
      .i_cmd_opcode(i_cmd_opcode), .i_cmd_afutag(i_cmd_afutag),
      .i_cmd_ea_or_obj(i_cmd_ea_or_obj), .i_cmd_dl(i_cmd_dl), .i_cmd_pl(i_cmd_pl),
      .i_cmd_pasid(i_cmd_pasid),
      .o_cmd_valid(o_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .o_cmd_opcode(o_cmd_opcode), .o_cmd_afutag(o_cmd_afutag),
      .o_cmd_ea_or_obj(o_cmd_ea_or_obj), .o_cmd_dl(o_cmd_dl), .o_cmd_pl(o_cmd_pl),
      .o_cmd_actag(o_cmd_actag), .o_cmd_pasid(o_cmd_pasid),
      .wdata_rdrq(wdata_rdrq), .err_pasid(err_pasid),
      .stat_miss_cnt(stat_miss_cnt), .stat_cmd_cnt(stat_cmd_cnt)
   );

   // Transfers and rdrq pulses are logged half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (resetn && o_cmd_valid && o_cmd_ready)
         obs.push_back(out_t'{o_cmd_opcode, o_cmd_actag, o_cmd_pasid});
      if (wdata_rdrq)
         rdrq_cnt++;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [19:0] pasid, input logic [7:0] op);
      int n = 0;
      i_cmd_valid  = 1'b1;
      i_cmd_pasid  = pasid;
      i_cmd_opcode = op;
      i_cmd_afutag = 16'hA000 | 16'(pasid[11:0]);
      while (!i_cmd_ready && n < 100) begin
         tick();
         n++;
      end
      check_val("send_timeout", 64'(n >= 100), 64'd0);
      tick();
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_outs(input string tag, input int k);
      int n = 0;
      while (obs.size() < k && n < 100) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check_val({tag, "_count"}, 64'(obs.size()), 64'(k));
   endtask

   task automatic check_out(input string tag, input int i, input out_t exp);
      out_t got;
      got = (i < obs.size()) ? obs[i] : '0;
      check_val(tag, 64'(got), 64'(exp));
   endtask

   initial begin
      resetn = 1'b0;
      cfg_actag_base = 12'h100; cfg_pasid_base = '0; cfg_pasid_mask = '0; cfg_flush = 1'b0;
      inval_valid = 1'b0; inval_pasid = '0;
      i_cmd_valid = 1'b0; i_cmd_opcode = '0; i_cmd_afutag = '0;
      i_cmd_ea_or_obj = 68'h1_2345_6789_ABCD_EF01; i_cmd_dl = 2'd1; i_cmd_pl = 3'd2; i_cmd_pasid = '0;
      o_cmd_ready = 1'b1;
      repeat (3) tick();
      check_val("rst_o_valid", 64'(o_cmd_valid), 64'd0);
      check_val("rst_i_ready", 64'(i_cmd_ready), 64'd0);
      check_val("rst_inval_ready", 64'(inval_ready), 64'd0);
      check_val("rst_miss_cnt", 64'(stat_miss_cnt), 64'd0);
      resetn = 1'b1;
      tick();

      // 1: first command misses -> assign_actag then the DMA write
      send(20'h041, 8'h20);
      wait_outs("t1", 2);
      check_out("t1_assign", 0, out_t'{8'h50, 12'h101, 20'h041});
      check_out("t1_cmd",    1, out_t'{8'h20, 12'h101, 20'h041});
      check_val("t1_rdrq", 64'(rdrq_cnt), 64'd1);
      check_val("t1_miss", 64'(stat_miss_cnt), 64'd1);
      check_val("t1_cmdcnt", 64'(stat_cmd_cnt), 64'd1);
      check_val("t1_ea", 64'(o_cmd_ea_or_obj[63:0]), 64'h2345_6789_ABCD_EF01);
      obs.delete();

      // 2: hit has 2-cycle latency; same idx with new tag misses
      send(20'h041, 8'h20);
      tick();
      check_val("t2_hit_latency", 64'({o_cmd_valid, o_cmd_opcode}), 64'h120);
      send(20'h141, 8'h30);
      wait_outs("t2", 3);
      check_out("t2_hit",    0, out_t'{8'h20, 12'h101, 20'h041});
      check_out("t2_assign", 1, out_t'{8'h50, 12'h101, 20'h141});
      check_out("t2_cmd",    2, out_t'{8'h30, 12'h101, 20'h141});
      check_val("t2_miss", 64'(stat_miss_cnt), 64'd2);
      check_val("t2_rdrq", 64'(rdrq_cnt), 64'd3);
      obs.delete();

      // 3: backpressure with a miss pending
      o_cmd_ready = 1'b0;
      send(20'h0C5, 8'h20);
      tick();
      for (int c = 0; c < 5; c++) begin
         check_val("t3_hold", 64'({o_cmd_valid, o_cmd_opcode, o_cmd_actag, i_cmd_ready}),
                   64'({1'b1, 8'h50, 12'h105, 1'b0}));
         tick();
      end
      check_val("t3_no_rdrq", 64'(rdrq_cnt), 64'd3);
      o_cmd_ready = 1'b1;
      wait_outs("t3", 2);
      check_out("t3_assign", 0, out_t'{8'h50, 12'h105, 20'h0C5});
      check_out("t3_cmd",    1, out_t'{8'h20, 12'h105, 20'h0C5});
      check_val("t3_rdrq", 64'(rdrq_cnt), 64'd4);
      obs.delete();

      // 4: invalidate colliding with an assign write is held off one cycle
      send(20'h007, 8'h10);
      inval_valid = 1'b1;
      inval_pasid = 20'h141;
      check_val("t4_inval_blocked", 64'(inval_ready), 64'd0);
      tick();
      check_val("t4_inval_ready", 64'(inval_ready), 64'd1);
      tick();
      inval_valid = 1'b0;
      wait_outs("t4a", 2);
      send(20'h141, 8'h20);
      wait_outs("t4", 4);
      check_out("t4_assign7", 0, out_t'{8'h50, 12'h107, 20'h007});
      check_out("t4_remiss",  2, out_t'{8'h50, 12'h101, 20'h141});
      check_out("t4_cmd",     3, out_t'{8'h20, 12'h101, 20'h141});
      check_val("t4_miss", 64'(stat_miss_cnt), 64'd5);
      obs.delete();

      // 5: flush while a hit sits in S1
      send(20'h141, 8'h30);
      cfg_flush = 1'b1;
      tick();
      cfg_flush = 1'b0;
      check_val("t5_hit_issued", 64'({o_cmd_valid, o_cmd_opcode}), 64'h130);
      send(20'h0C5, 8'h01);
      send(20'h041, 8'h20);
      wait_outs("t5", 5);
      check_out("t5_c5_reassign", 1, out_t'{8'h50, 12'h105, 20'h0C5});
      check_out("t5_41_reassign", 3, out_t'{8'h50, 12'h101, 20'h041});
      check_out("t5_41_cmd",      4, out_t'{8'h20, 12'h101, 20'h041});
      check_val("t5_miss", 64'(stat_miss_cnt), 64'd7);
      obs.delete();

      // 6: PASID window error is sticky; acTag base wraps at 12 bits
      cfg_pasid_mask = 20'h1C0;
      cfg_pasid_base = 20'h040;
      check_val("t6_err_clear", 64'(err_pasid), 64'd0);
      send(20'h081, 8'h20);
      tick();
      check_val("t6_err_set", 64'(err_pasid), 64'd1);
      send(20'h041, 8'h10);
      cfg_actag_base = 12'hFFF;
      send(20'h003, 8'h10);
      wait_outs("t6", 6);
      check_out("t6_err_cmd", 1, out_t'{8'h20, 12'h101, 20'h081});
      check_out("t6_wrap",    4, out_t'{8'h50, 12'h002, 20'h003});
      check_val("t6_err_sticky", 64'(err_pasid), 64'd1);
      check_val("t6_miss", 64'(stat_miss_cnt), 64'd10);
      check_val("t6_cmdcnt", 64'(stat_cmd_cnt), 64'd12);
      check_val("t6_rdrq", 64'(rdrq_cnt), 64'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
